datapath_raiz: RTL and testbench
================================

# datapath_raiz

Register datapath for the bit-pair restoring integer square root of a 16-bit unsigned radicand. It holds the radicand shift register, the partial remainder, the partial root and the iteration counter. It executes the one-hot step strobes issued by the square-root control FSM, and it returns the sign of the trial subtraction and the last-iteration flag to that FSM. Result: 8-bit root and 9-bit remainder, valid while the FSM holds DONE.

## Interface
Parameters:
- none; widths are fixed at radicand 16, root 8, remainder 9, trial/remainder register 16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_X  in  16  radicand, sampled only while in_RST=1.
- in_RST  in  1  synchronous load/clear strobe (FSM START).
- in_S1  in  1  shift-in strobe (FSM STEP1).
- in_S2  in  1  accept strobe (FSM OPERATE).
- in_S3  in  1  iterate strobe (FSM ITERATE).
- in_S4  in  1  step-end strobe (FSM STEP2).
- out_Q  out  16  trial difference A − {R,2'b01}, combinational; bit 15 is the negative flag.
- out_K  out  1  high when counter K == 0, i.e. the current iteration is the last.
- out_root  out  8  partial/final root R.
- out_rem  out  9  A[8:0], final remainder.

## Operation
Registers:
- X (16): radicand shift register.
- A (16): partial remainder.
- R (8): partial root.
- K (3): iteration counter.
- B (1): accept flag.

Priority when several strobes are high in the same cycle: in_RST > in_S1 > in_S2 > in_S3 > in_S4. Only the highest-priority strobe acts. With no strobe high, all registers hold.

- in_RST: X←in_X, A←0, R←0, K←7, B←0.
- in_S1: A←{A[13:0], X[15:14]}, X←{X[13:0], 2'b00}.
- in_S2: A←out_Q, B←1.
- in_S3: R←{R[6:0], B}, K←K−1. K wraps 0→7; the wrap is harmless because the FSM leaves for DONE.
- in_S4: B←0.

Combinational outputs:
- out_Q = A − {6'b0, R, 2'b01}, computed modulo 2^16.
- out_K = (K == 3'd0).

Arithmetic bounds:
- Before a shift, A ≤ 2R ≤ 510.
- After a shift, A ≤ 2043, so bit 15 of out_Q is an exact sign bit.

Iterations: exactly 8 in_S3 pulses per operation. in_S3 is sampled by the FSM with out_K, and the 8th in_S3 occurs when K=0.

Result: after the 8th in_S3, R = floor(sqrt(X0)) and A = X0 − R², where X0 is the radicand loaded at in_RST.

## Timing
- All register updates occur on the rising clk edge following the strobe.
- out_Q and out_K are valid in the same cycle as the register state they derive from. Zero latency, so the FSM's CHECK state sees out_Q computed from A after the preceding S1.
- Asynchronous reset (rst=0), immediately and regardless of clk: X=0, A=0, R=0, K=0, B=0.
- Values while rst=0: out_Q=16'hFFFF, out_K=1, out_root=0, out_rem=0.
- Reset mid-operation aborts the computation. A subsequent in_RST reloads in_X; no residue remains from the aborted run.
- in_RST during an operation: restarts on the next edge with the new in_X.
- Outputs hold after the final in_S3 until the next in_RST or rst. DONE is a hold state, so out_root and out_rem are stable.
- Per-iteration latency is set by the FSM: 4 cycles (S1, CHECK, S3, S4) or 5 cycles when S2 is taken. Total 32–40 cycles plus START/DONE.

## Structure
- Package raiz_pkg holds shared constants:
  - RAD_W=16, ROOT_W=8, REM_W=9.
  - ITER_INIT=3'd7.
  - Strobe bit positions, shared with the control FSM and the bench.
- Sub-module sub_trial_raiz: combinational 16-bit subtractor producing out_Q from A and R. It is reused by the bench's reference model.
- Registers, priority mux and counter stay in datapath_raiz.

## Test plan
- Load in_X=0, drive the full FSM strobe sequence → 8 iterations, out_Q[15]=1 at every CHECK, out_root=0, out_rem=0.
- in_X=144 → out_root=12, out_rem=0; B is set in exactly the iterations corresponding to root bits 00001100.
- in_X=65535 → out_root=255, out_rem=510; every CHECK sees out_Q[15]=0; no overflow into bit 15.
- in_X=2 → out_root=1, out_rem=1. in_X=65025 → out_root=255, out_rem=0.
- Assert rst=0 mid-iteration after the 4th in_S3 → all outputs go to the reset values asynchronously. After reload with in_X=81 and a full run → out_root=9, out_rem=0.
- Drive in_RST and in_S1 together, then in_S2 and in_S3 together → only the higher-priority action occurs (load; accept with R unchanged). out_K is 1 exactly when K=0 and falls after the next in_S3 wrap.

Source files
------------

// File: rtl/raiz_pkg.sv
// raiz_pkg: constants shared by the square-root datapath, its control FSM
// and the bench.
//   RAD_W / ROOT_W / REM_W : radicand, root and remainder widths.
//   ACC_W                  : width of the partial-remainder / trial register.
//   ITER_INIT              : iteration counter load value (8 iterations).
//   STB_*                  : bit positions of the one-hot step strobes.
package raiz_pkg;
  localparam int RAD_W  = 16;
  localparam int ROOT_W = 8;
  localparam int REM_W  = 9;
  localparam int ACC_W  = 16;

  localparam logic [2:0] ITER_INIT = 3'd7;

  // Strobe vector positions; a lower index means a higher priority.
  localparam int STB_RST = 0;  // START   : load radicand, clear state
  localparam int STB_S1  = 1;  // STEP1   : shift two radicand bits into A
  localparam int STB_S2  = 2;  // OPERATE : accept the trial difference
  localparam int STB_S3  = 3;  // ITERATE : shift accept bit into root
  localparam int STB_S4  = 4;  // STEP2   : clear accept flag
  localparam int STB_W   = 5;
endpackage

// File: rtl/sub_trial_raiz.sv
// sub_trial_raiz: trial subtraction of one restoring square-root step.
//   a_i : partial remainder A (16 bits)
//   r_i : partial root R (8 bits)
//   q_o : A - (4R + 1), modulo 2^16; bit 15 is the sign of the trial
module sub_trial_raiz
  import raiz_pkg::*;
(
  input  logic [ACC_W-1:0]  a_i,
  input  logic [ROOT_W-1:0] r_i,
  output logic [ACC_W-1:0]  q_o
);
  logic [ACC_W-1:0] trial_sub;

  // {R,01} is 4R+1, the increment from (2R)^2 to (2R+1)^2.
  assign trial_sub = {{(ACC_W-ROOT_W-2){1'b0}}, r_i, 2'b01};
  assign q_o       = a_i - trial_sub;
endmodule

// File: rtl/datapath_raiz.sv
// datapath_raiz: register datapath for a bit-pair restoring 16-bit integer
// square root, driven by one-hot strobes from an external control FSM.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   in_X      : radicand, captured on in_RST
//   in_RST    : load radicand / clear state (highest priority)
//   in_S1     : shift next two radicand bits into the partial remainder
//   in_S2     : accept trial difference, set accept flag
//   in_S3     : shift accept flag into root, decrement counter
//   in_S4     : clear accept flag (lowest priority)
//   out_Q     : combinational trial difference A - {R,2'b01}; bit 15 = negative
//   out_K     : high while the iteration counter is zero (last iteration)
//   out_root  : partial / final root
//   out_rem   : final remainder A[8:0]
// Strobe semantics: each strobe is a single-cycle command sampled on the
// rising edge; only the highest-priority asserted strobe acts, and with no
// strobe asserted every register holds.
module datapath_raiz
  import raiz_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RAD_W-1:0]  in_X,
  input  logic              in_RST,
  input  logic              in_S1,
  input  logic              in_S2,
  input  logic              in_S3,
  input  logic              in_S4,
  output logic [ACC_W-1:0]  out_Q,
  output logic              out_K,
  output logic [ROOT_W-1:0] out_root,
  output logic [REM_W-1:0]  out_rem
);
  logic [RAD_W-1:0]  x_q, x_d;
  logic [ACC_W-1:0]  a_q, a_d;
  logic [ROOT_W-1:0] r_q, r_d;
  logic [2:0]        k_q, k_d;
  logic              b_q, b_d;
  logic [STB_W-1:0]  stb;
  logic [ACC_W-1:0]  trial_q;

  assign stb[STB_RST] = in_RST;
  assign stb[STB_S1]  = in_S1;
  assign stb[STB_S2]  = in_S2;
  assign stb[STB_S3]  = in_S3;
  assign stb[STB_S4]  = in_S4;

  sub_trial_raiz u_trial (
    .a_i (a_q),
    .r_i (r_q),
    .q_o (trial_q)
  );

  always_comb begin
    x_d = x_q;
    a_d = a_q;
    r_d = r_q;
    k_d = k_q;
    b_d = b_q;
    if (stb[STB_RST]) begin
      x_d = in_X;
      a_d = '0;
      r_d = '0;
      k_d = ITER_INIT;
      b_d = 1'b0;
    end else if (stb[STB_S1]) begin
      a_d = {a_q[ACC_W-3:0], x_q[RAD_W-1:RAD_W-2]};
      x_d = {x_q[RAD_W-3:0], 2'b00};
    end else if (stb[STB_S2]) begin
      a_d = trial_q;
      b_d = 1'b1;
    end else if (stb[STB_S3]) begin
      r_d = {r_q[ROOT_W-2:0], b_q};
      // Wraps 0 -> 7 on the last iteration; the FSM is leaving for DONE.
      k_d = k_q - 3'd1;
    end else if (stb[STB_S4]) begin
      b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      a_q <= '0;
      r_q <= '0;
      k_q <= '0;
      b_q <= 1'b0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      r_q <= r_d;
      k_q <= k_d;
      b_q <= b_d;
    end
  end

  assign out_Q    = trial_q;
  assign out_K    = (k_q == 3'd0);
  assign out_root = r_q;
  assign out_rem  = a_q[REM_W-1:0];
endmodule

// File: tb/tb_datapath_raiz.sv
module tb_datapath_raiz;
  import raiz_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] in_X;
  logic        in_RST, in_S1, in_S2, in_S3, in_S4;
  logic [15:0] out_Q;
  logic        out_K;
  logic [7:0]  out_root;
  logic [8:0]  out_rem;

  int checks   = 0;
  int failures = 0;

  datapath_raiz dut (
    .clk      (clk),
    .rst      (rst),
    .in_X     (in_X),
    .in_RST   (in_RST),
    .in_S1    (in_S1),
    .in_S2    (in_S2),
    .in_S3    (in_S3),
    .in_S4    (in_S4),
    .out_Q    (out_Q),
    .out_K    (out_K),
    .out_root (out_root),
    .out_rem  (out_rem)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_strobes();
    in_RST = 0; in_S1 = 0; in_S2 = 0; in_S3 = 0; in_S4 = 0;
  endtask

  // Called just after a falling edge; holds the strobe across one rising edge.
  task automatic pulse(input int which);
    clear_strobes();
    case (which)
      STB_RST: in_RST = 1;
      STB_S1:  in_S1  = 1;
      STB_S2:  in_S2  = 1;
      STB_S3:  in_S3  = 1;
      default: in_S4  = 1;
    endcase
    @(negedge clk);
    clear_strobes();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Plays the control FSM for n_iter iterations and checks against the model.
  task automatic run_op(input logic [15:0] x, input int n_iter);
    int x0, top, top_prev, rp, r_exp, trial;
    x0 = int'(x);
    in_X = x;
    pulse(STB_RST);
    in_X = 16'($urandom);
    check("load_root", 16'(out_root), 16'd0);
    check("load_rem", 16'(out_rem), 16'd0);
    check("load_k", 16'(out_K), 16'd0);
    for (int i = 0; i < n_iter; i++) begin
      top_prev = x0 >> (16 - 2 * i);
      top      = x0 >> (14 - 2 * i);
      rp       = isqrt(top_prev);
      trial    = top - (2 * rp + 1) * (2 * rp + 1);
      pulse(STB_S1);
      check($sformatf("check_q x=%0d i=%0d", x0, i), out_Q, 16'(trial));
      check($sformatf("check_k x=%0d i=%0d", x0, i), 16'(out_K), 16'(i == 7));
      idle(1);
      if (trial >= 0) pulse(STB_S2);
      pulse(STB_S3);
      r_exp = isqrt(top);
      check($sformatf("iter_root x=%0d i=%0d", x0, i), 16'(out_root), 16'(r_exp));
      pulse(STB_S4);
    end
    if (n_iter == 8) begin
      r_exp = isqrt(x0);
      idle(2);
      check($sformatf("final_root x=%0d", x0), 16'(out_root), 16'(r_exp));
      check($sformatf("final_rem x=%0d", x0), 16'(out_rem), 16'(x0 - r_exp * r_exp));
      check($sformatf("final_k x=%0d", x0), 16'(out_K), 16'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rx;
    clear_strobes();
    in_X = '0;
    rst  = 0;
    #2;
    check("rst_q", out_Q, 16'hFFFF);
    check("rst_k", 16'(out_K), 16'd1);
    check("rst_root", 16'(out_root), 16'd0);
    check("rst_rem", 16'(out_rem), 16'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // Directed radicands, including extremes.
    run_op(16'd0, 8);
    run_op(16'd144, 8);
    run_op(16'd65535, 8);
    run_op(16'd2, 8);
    run_op(16'd65025, 8);

    // Asynchronous reset after the 4th iterate, then reload.
    run_op(16'd50000, 4);
    #2 rst = 0;
    #1;
    check("midrst_q", out_Q, 16'hFFFF);
    check("midrst_k", 16'(out_K), 16'd1);
    check("midrst_root", 16'(out_root), 16'd0);
    check("midrst_rem", 16'(out_rem), 16'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    run_op(16'd81, 8);

    // Restart in the middle of an operation.
    run_op(16'd40000, 3);
    run_op(16'd1000, 8);

    // Priority: load wins over shift.
    in_X = 16'hC000;
    in_RST = 1; in_S1 = 1;
    @(negedge clk);
    clear_strobes();
    check("prio_load_rem", 16'(out_rem), 16'd0);
    check("prio_load_q", out_Q, 16'hFFFF);
    check("prio_load_k", 16'(out_K), 16'd0);
    pulse(STB_S1);
    check("prio_shift_rem", 16'(out_rem), 16'd3);
    check("prio_shift_q", out_Q, 16'd2);
    // Accept wins over iterate: A takes the trial, root and counter unchanged.
    in_S2 = 1; in_S3 = 1;
    @(negedge clk);
    clear_strobes();
    check("prio_acc_rem", 16'(out_rem), 16'd2);
    check("prio_acc_root", 16'(out_root), 16'd0);
    check("prio_acc_k", 16'(out_K), 16'd0);
    pulse(STB_S3);
    check("prio_iter_root", 16'(out_root), 16'd1);

    // Randomized radicands.
    for (int n = 0; n < 12; n++) begin
      rx = 16'($urandom_range(0, 65535));
      run_op(rx, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
